// File: rtl/power_feature_extractor.sv
// Power-trace feature extractor: accumulates 2**LOG2_N accepted Q3.7 samples and
// emits energy, peak, mean and bus Hamming distance with a one-cycle valid pulse.
module power_feature_extractor #(
    parameter int LOG2_N = 3,
    parameter int FRAC   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic [9:0] sample,
    input  logic [7:0] bus_data,
    output logic [9:0] energy,
    output logic [9:0] peak_power,
    output logic [9:0] mean_power,
    output logic [7:0] hamming_dist,
    output logic       feat_valid,
    output logic       state_dbg
);

    localparam int SUM_W = 10 + LOG2_N;
    localparam int SQ_W  = 20 + LOG2_N;
    localparam int HD_W  = 8 + LOG2_N;
    localparam logic [LOG2_N-1:0] LAST = '1;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [SUM_W-1:0]  sum_acc;
    logic [SQ_W-1:0]   sq_acc;
    logic [HD_W-1:0]   hd_acc;
    logic [9:0]        peak;
    logic [7:0]        prev_bus;
    logic [LOG2_N-1:0] count;
    logic [19:0]       sample_sq;
    logic [3:0]        bus_flips;
    logic              accept;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // Handshake: a sample transfers on a rising edge where sample_valid && sample_ready.
    // sample_ready is high only in ACCUM with clear low; valid may drop at any time.
    assign accept    = sample_valid && sample_ready;
    assign sample_sq = {10'd0, sample} * {10'd0, sample};
    assign bus_flips = popcount8(bus_data ^ prev_bus);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sample_ready = 1'b0;
        case (state)
            ACCUM: begin
                sample_ready = !clear;
                if (sample_valid && !clear && count == LAST) begin
                    state_nxt = EMIT;
                end
            end
            EMIT:    state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
        if (clear) begin
            state_nxt = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_acc      <= '0;
            sq_acc       <= '0;
            hd_acc       <= '0;
            peak         <= '0;
            prev_bus     <= '0;
            count        <= '0;
            energy       <= '0;
            peak_power   <= '0;
            mean_power   <= '0;
            hamming_dist <= '0;
            feat_valid   <= 1'b0;
        end else begin
            feat_valid <= 1'b0;
            if (clear) begin
                // Abort the window; outputs and the bus history survive.
                sum_acc <= '0;
                sq_acc  <= '0;
                hd_acc  <= '0;
                peak    <= '0;
                count   <= '0;
            end else if (state == EMIT) begin
                mean_power   <= sum_acc[LOG2_N +: 10];
                energy       <= (|sq_acc[SQ_W-1:FRAC+10]) ? 10'h3FF : sq_acc[FRAC +: 10];
                peak_power   <= peak;
                hamming_dist <= (|hd_acc[HD_W-1:8]) ? 8'hFF : hd_acc[7:0];
                feat_valid   <= 1'b1;
                sum_acc      <= '0;
                sq_acc       <= '0;
                hd_acc       <= '0;
                peak         <= '0;
                count        <= '0;
            end else if (accept) begin
                sum_acc  <= sum_acc + SUM_W'(sample);
                sq_acc   <= sq_acc + SQ_W'(sample_sq);
                hd_acc   <= hd_acc + HD_W'(bus_flips);
                prev_bus <= bus_data;
                count    <= count + 1'b1;
                if (count == '0 || sample > peak) begin
                    peak <= sample;
                end
            end
        end
    end

endmodule

// File: tb/tb_power_feature_extractor.sv
// Bench for power_feature_extractor: directed scenarios plus random traffic,
// scored against a window-level model of the feature definitions.
module tb_power_feature_extractor;

    localparam int N = 8;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst;
    logic       clear;
    logic       sample_valid;
    logic       sample_ready;
    logic [9:0] sample;
    logic [7:0] bus_data;
    logic [9:0] energy;
    logic [9:0] peak_power;
    logic [9:0] mean_power;
    logic [7:0] hamming_dist;
    logic       feat_valid;
    logic       state_dbg;

    logic       s32_valid;
    logic       s32_ready;
    logic [9:0] s32_sample;
    logic [7:0] s32_bus;
    logic [9:0] e32;
    logic [9:0] pk32;
    logic [9:0] mn32;
    logic [7:0] hd32;
    logic       fv32;
    logic       st32;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    power_feature_extractor #(.LOG2_N(3), .FRAC(7)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample       (sample),
        .bus_data     (bus_data),
        .energy       (energy),
        .peak_power   (peak_power),
        .mean_power   (mean_power),
        .hamming_dist (hamming_dist),
        .feat_valid   (feat_valid),
        .state_dbg    (state_dbg)
    );

    power_feature_extractor #(.LOG2_N(5), .FRAC(7)) u_dut32 (
        .clk          (clk),
        .rst          (rst),
        .clear        (1'b0),
        .sample_valid (s32_valid),
        .sample_ready (s32_ready),
        .sample       (s32_sample),
        .bus_data     (s32_bus),
        .energy       (e32),
        .peak_power   (pk32),
        .mean_power   (mn32),
        .hamming_dist (hd32),
        .feat_valid   (fv32),
        .state_dbg    (st32)
    );

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [37:0] exp_q[$];
    int          m_win[$];
    int          m_hd      = 0;
    int          m_prev    = 0;
    bit          m_pending = 1'b0;
    logic [37:0] m_out     = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Features of a complete window, straight from their arithmetic definitions.
    function automatic logic [37:0] window_features(input int q[$], input int hd, input int log2n);
        int sum, sq, pk, en, mn, hs;
        logic [9:0] e10, p10, m10;
        logic [7:0] h8;
        sum = 0;
        sq  = 0;
        pk  = 0;
        foreach (q[i]) begin
            sum += q[i];
            sq  += q[i] * q[i];
            if (q[i] > pk) pk = q[i];
        end
        en  = ((sq >> 7) > 1023) ? 1023 : (sq >> 7);
        mn  = sum >> log2n;
        hs  = (hd > 255) ? 255 : hd;
        e10 = en[9:0];
        p10 = pk[9:0];
        m10 = mn[9:0];
        h8  = hs[7:0];
        return {e10, p10, m10, h8};
    endfunction

    // ---------------- driver ----------------
    // One clock cycle of stimulus; called and returning 1 time unit after a rising edge.
    task automatic drive(input bit v, input int s, input int b, input bit clr);
        bit exp_fv;
        sample_valid = v;
        sample       = s[9:0];
        bus_data     = b[7:0];
        clear        = clr;
        #1;
        check("sample_ready", sample_ready, !m_pending && !clr);
        exp_fv = 1'b0;
        if (clr) begin
            m_win.delete();
            m_hd = 0;
            if (m_pending) void'(exp_q.pop_front());
            m_pending = 1'b0;
        end else if (m_pending) begin
            m_pending = 1'b0;
            exp_fv    = 1'b1;
            m_out     = exp_q.pop_front();
        end else if (v) begin
            m_win.push_back(s);
            m_hd  += $countones(b[7:0] ^ m_prev[7:0]);
            m_prev = b;
            if (m_win.size() == N) begin
                exp_q.push_back(window_features(m_win, m_hd, 3));
                m_pending = 1'b1;
                m_win.delete();
                m_hd = 0;
            end
        end
        @(posedge clk);
        #1;
        check("feat_valid", feat_valid, exp_fv);
        check("features", {energy, peak_power, mean_power, hamming_dist}, m_out);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0);
    endtask

    task automatic run32();
        int q[$];
        int hd;
        int prev;
        int b;
        hd   = 0;
        prev = 0;
        for (int i = 0; i < 32; i++) begin
            b = (i % 2 == 0) ? 8'hFF : 8'h00;
            s32_valid  = 1'b1;
            s32_sample = 10'($urandom_range(0, 1023));
            s32_bus    = b[7:0];
            q.push_back(int'(s32_sample));
            hd  += $countones(b[7:0] ^ prev[7:0]);
            prev = b;
            #1;
            check("n32_ready", s32_ready, 1'b1);
            @(posedge clk);
            #1;
            check("n32_fv_early", fv32, 1'b0);
        end
        s32_valid = 1'b0;
        check("n32_ready_emit", s32_ready, 1'b0);
        @(posedge clk);
        #1;
        check("n32_fv", fv32, 1'b1);
        check("n32_features", {e32, pk32, mn32, hd32}, window_features(q, hd, 5));
        check("n32_hd_sat", hd32, 8'd255);
        @(posedge clk);
        #1;
        check("n32_fv_pulse", fv32, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t3[8];
        t3 = '{10, 20, 5, 20, 7, 3, 1, 0};
        rst          = 1'b0;
        clear        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        bus_data     = '0;
        s32_valid    = 1'b0;
        s32_sample   = '0;
        s32_bus      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {energy, peak_power, mean_power, hamming_dist}, 38'd0);
        check("reset_fv", feat_valid, 1'b0);
        rst = 1'b1;

        // Constant window with fixed bus value.
        for (int i = 0; i < N; i++) drive(1'b1, 77, 8'h0F, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        check("t1_energy", energy, 10'd370);
        check("t1_hd", hamming_dist, 8'd4);
        idle(1);

        // Full-scale samples with toggling bus: energy saturates.
        for (int i = 0; i < N; i++) drive(1'b1, 1023, (i % 2 == 0) ? 8'h00 : 8'hFF, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        check("t2_energy_sat", energy, 10'd1023);

        // Ties and gaps; a sample offered during EMIT is dropped.
        for (int i = 0; i < N; i++) begin
            idle($urandom_range(0, 3));
            drive(1'b1, t3[i], $urandom_range(0, 255), 1'b0);
        end
        drive(1'b1, 99, 8'h55, 1'b0);
        check("t3_peak", peak_power, 10'd20);
        check("t3_mean", mean_power, 10'd8);
        idle(2);

        // Partial window aborted by clear.
        for (int i = 0; i < 5; i++) drive(1'b1, $urandom_range(0, 1023), $urandom_range(0, 255), 1'b0);
        drive(1'b1, 500, 8'hAA, 1'b1);
        for (int i = 0; i < N; i++) drive(1'b1, 40, $urandom_range(0, 255), 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        check("t4_mean", mean_power, 10'd40);
        check("t4_energy", energy, 10'd100);

        // Asynchronous reset mid-window.
        for (int i = 0; i < 4; i++) drive(1'b1, $urandom_range(1, 1023), $urandom_range(0, 255), 1'b0);
        sample_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_outputs", {energy, peak_power, mean_power, hamming_dist}, 38'd0);
        check("async_rst_fv", feat_valid, 1'b0);
        m_win.delete();
        m_hd      = 0;
        m_prev    = 0;
        m_pending = 1'b0;
        m_out     = '0;
        exp_q.delete();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) drive(1'b1, $urandom_range(0, 1023), $urandom_range(0, 255), 1'b0);
        idle(1);

        // Random traffic: gaps, occasional clears, offers during EMIT.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) ? $urandom_range(0, 1023) : $urandom_range(0, 63),
                  $urandom_range(0, 255),
                  $urandom_range(0, 29) == 0);
        end
        idle(2);
        check("exp_q_drained", exp_q.size(), 0);

        run32();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
